alu_exec_stage: RTL

//  Buffered execute stage wrapping the 32-bit combinational ALU. Accepts operand/op

---
 rtl/alu_exec_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Buffered execute stage: queues operand/op commands in a FIFO, feeds the head to an
// external ALU and registers its outputs into a valid/ready output slot.
module alu_exec_stage #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_a,
  input  logic [31:0]                in_b,
  input  logic [2:0]                 in_op,
  input  logic [TAG_W-1:0]           in_tag,
  output logic [31:0]                alu_a,
  output logic [31:0]                alu_b,
  output logic [2:0]                 alu_ctr,
  input  logic [31:0]                alu_result,
  input  logic                       alu_overflow,
  input  logic                       alu_zero,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_result,
  output logic                       out_overflow,
  output logic                       out_zero,
  output logic                       out_illegal,
  output logic [TAG_W-1:0]           out_tag,
  output logic                       trap_sticky,
  input  logic                       trap_clear,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [2:0] OP_RSVD = 3'b011;

  logic [31:0]      mem_a_q   [DEPTH];
  logic [31:0]      mem_b_q   [DEPTH];
  logic [2:0]       mem_op_q  [DEPTH];
  logic [TAG_W-1:0] mem_tag_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_result_q, out_result_d;
  logic             out_overflow_q, out_overflow_d;
  logic             out_zero_q, out_zero_d;
  logic             out_illegal_q, out_illegal_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic             trap_q, trap_d;
  logic             head_valid_s, push_s, load_s;

  assign head_valid_s = (count_q != {CNT_W{1'b0}});
  assign in_ready     = ~rst & (count_q != FULL_CNT);
  assign push_s       = in_valid & in_ready;
  assign load_s       = head_valid_s & (~out_valid_q | out_ready);

  assign count        = count_q;
  assign out_valid    = out_valid_q;
  assign out_result   = out_result_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;
  assign out_illegal  = out_illegal_q;
  assign out_tag      = out_tag_q;
  assign trap_sticky  = trap_q;

  // ALU pins are forced to zero when no command is queued
  always_comb begin
    if (head_valid_s) begin
      alu_a   = mem_a_q[rd_ptr_q];
      alu_b   = mem_b_q[rd_ptr_q];
      alu_ctr = mem_op_q[rd_ptr_q];
    end else begin
      alu_a   = 32'd0;
      alu_b   = 32'd0;
      alu_ctr = 3'd0;
    end
  end

  always_comb begin
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (load_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, load_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    out_valid_d    = out_valid_q;
    out_result_d   = out_result_q;
    out_overflow_d = out_overflow_q;
    out_zero_d     = out_zero_q;
    out_illegal_d  = out_illegal_q;
    out_tag_d      = out_tag_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      out_tag_d   = mem_tag_q[rd_ptr_q];
      if (alu_ctr == OP_RSVD) begin
        out_result_d   = 32'd0;
        out_overflow_d = 1'b0;
        out_zero_d     = 1'b0;
        out_illegal_d  = 1'b1;
      end else begin
        out_result_d   = alu_result;
        out_overflow_d = alu_overflow;
        out_zero_d     = alu_zero;
        out_illegal_d  = 1'b0;
      end
    end else if (out_valid_q & out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
    // a delivered overflow takes priority over a clear in the same cycle
    if (out_valid_q & out_ready & out_overflow_q) begin
      trap_d = 1'b1;
    end else if (trap_clear) begin
      trap_d = 1'b0;
    end else begin
      trap_d = trap_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_a_q[wr_ptr_q]   <= in_a;
      mem_b_q[wr_ptr_q]   <= in_b;
      mem_op_q[wr_ptr_q]  <= in_op;
      mem_tag_q[wr_ptr_q] <= in_tag;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= {PTR_W{1'b0}};
      rd_ptr_q       <= {PTR_W{1'b0}};
      count_q        <= {CNT_W{1'b0}};
      out_valid_q    <= 1'b0;
      out_result_q   <= 32'd0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_illegal_q  <= 1'b0;
      out_tag_q      <= {TAG_W{1'b0}};
      trap_q         <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      out_valid_q    <= out_valid_d;
      out_result_q   <= out_result_d;
      out_overflow_q <= out_overflow_d;
      out_zero_q     <= out_zero_d;
      out_illegal_q  <= out_illegal_d;
      out_tag_q      <= out_tag_d;
      trap_q         <= trap_d;
    end
  end

endmodule
